adc_sequencer: RTL and testbench
================================

// Module: adc_sequencer
// PURPOSE
// Upstream controller and downstream consumer for the 10-bit SPI ADC front end.
// - Generates periodic start pulses and channel selects; waits out the SPI frame; captures voltage.
// - Keeps a per-channel box-car average of 2^AVG_LOG2 samples.
// - Publishes each averaged sample with a one-cycle valid strobe to the audio/control logic.
// PARAMETERS
// PERIOD     32  sclk cycles from one START entry to the next; must be >= CONV_WAIT+4
// CONV_WAIT  18  sclk cycles spent in WAIT before voltage is treated as final (frame is 16 + margin)
// AVG_LOG2   2   log2 of samples averaged per channel; legal range 0..4
// PORTS
// sclk      in   1   ADC serial clock; all logic on posedge
// reset     in   1   asynchronous, active-high
// enable    in   1   level; run the conversion loop while high
// ch_mask   in   2   bit n = channel n is included in the round-robin
// voltage   in   10  parallel result from the ADC front end
// start     out  1   conversion request to the ADC front end
// channel   out  1   channel select to the ADC front end; stable for the whole frame
// sample0   out  10  latest averaged result, channel 0
// sample1   out  10  latest averaged result, channel 1
// valid     out  1   one-cycle strobe: sample[valid_ch] was just updated
// valid_ch  out  1   channel of the current valid strobe
// BEHAVIOUR
// - Reset: every output is 0; FSM goes to IDLE; all counters and accumulators are 0.
//   - Reset is taken immediately, including mid-frame.
// - FSM states: IDLE, START, WAIT, CAPTURE, HOLD.
//   - IDLE -> START when enable=1 and ch_mask != 0.
//   - START: start=1 for exactly 2 cycles, so the front end's negedge edge-detect sees it; then -> WAIT.
//   - WAIT: start=0 for CONV_WAIT cycles; then -> CAPTURE.
//   - CAPTURE: 1 cycle. Add voltage to acc[channel] and increment cnt[channel]; then -> HOLD.
//   - HOLD: wait until PERIOD cycles have elapsed since START entry.
//     - Then -> START if enable=1 and ch_mask != 0; otherwise -> IDLE.
// - Period counter clears on START entry and saturates at PERIOD-1.
//   - Conversion rate is exactly PERIOD cycles while running.
// - Channel choice is made on START entry: the next channel after the previous one that is set in ch_mask.
//   - Mask 01 or 10: always that channel. Mask 11: 0,1,0,1...
//   - After reset the "previous" channel is 1, so channel 0 goes first.
//   - channel holds from START entry through HOLD; ch_mask changes take effect only at the next START.
// - Averaging, per channel:
//   - acc is 10+AVG_LOG2 bits wide; sums cannot overflow.
//   - On the capture that brings cnt to 2^AVG_LOG2: sampleN <= (acc+voltage)>>AVG_LOG2 (truncating),
//     valid=1 and valid_ch=N for the following cycle, then acc and cnt clear.
//   - AVG_LOG2=0: every capture is published directly.
//   - sampleN keeps its value between updates.
// - enable falling mid-frame: the current frame completes through CAPTURE/HOLD; never abandon an SPI frame.
// - Entering IDLE clears every acc and cnt; sampleN is retained. Partial averages are discarded.
// - enable rising while in HOLD (after falling) still goes to START on period expiry.
// - valid is never high for two consecutive cycles; only one channel is captured per frame.
// STRUCTURE
// - Package adc_pkg: ADC_BITS=10, NUM_CH=2, typedef enum logic [2:0] seq_state_t {IDLE,START,WAIT,CAPTURE,HOLD}.
// - Sub-module channel_averager #(AVG_LOG2): one instance per channel.
//   - Inputs: add strobe, voltage, clear. Outputs: sample, done.
//   - Top level holds the FSM, the period/wait counters and the round-robin logic.
// TESTING (PERIOD=32, CONV_WAIT=18, AVG_LOG2=2; ADC model returns a programmable value)
// 1. Release reset with enable=1, mask=01, voltage=0x200.
//    -> start high 2 cycles every 32; channel=0; valid once after 4th capture, sample0=0x200, valid_ch=0.
// 2. mask=01; captured values 1,2,3,5 -> sample0=2 (11>>2); then 0x3FF x4 -> sample0=0x3FF, no overflow.
// 3. mask=11, voltage=ch?0x100:0x300 -> channel 0,1,0,1...
//    -> valid for ch0 after capture 7 with sample0=0x100; ch1 after capture 8 with sample1=0x300.
// 4. enable drops 5 cycles after start -> frame runs to CAPTURE, FSM enters IDLE, acc cleared.
//    -> re-enable needs 4 new captures before valid.
// 5. reset asserted during WAIT -> start, channel, valid, sample0/1 all 0 immediately; restart begins with channel 0.
// 6. mask=00 with enable=1 -> FSM stays in IDLE, start never asserts; mask 00->10 mid-HOLD -> next frame uses channel 1.

Source files
------------

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared widths, sequencer states and round-robin helper for the ADC sequencer
package adc_pkg;

    localparam int ADC_BITS = 10;
    localparam int NUM_CH   = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        CAPTURE,
        HOLD
    } seq_state_t;

    // Next enabled channel after prev; caller guarantees mask is non-zero.
    function automatic logic next_channel(input logic prev, input logic [NUM_CH-1:0] mask);
        return mask[~prev] ? ~prev : prev;
    endfunction

endpackage

// File: rtl/channel_averager.sv
// rtl/channel_averager.sv - box-car average of 2^AVG_LOG2 captures for one ADC channel
module channel_averager
    import adc_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                sclk,
    input  logic                reset,
    input  logic                add,
    input  logic                clear,
    input  logic [ADC_BITS-1:0] voltage,
    output logic [ADC_BITS-1:0] sample,
    output logic                done
);

    localparam int ACC_W = ADC_BITS + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADC_BITS-1:0] sample_q, sample_d;
    logic                done_q, done_d;
    logic [ACC_W-1:0]    sum;

    // Accumulator is wide enough that the full sum never overflows.
    assign sum = acc_q + ACC_W'(voltage);

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        done_d   = 1'b0;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add) begin
            if (cnt_q == LAST_CNT) begin
                sample_d = sum[ACC_W-1 -: ADC_BITS];
                done_d   = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign sample = sample_q;
    assign done   = done_q;

endmodule

// File: rtl/adc_sequencer.sv
// rtl/adc_sequencer.sv - periodic start/channel sequencing for the SPI ADC with per-channel averaging
module adc_sequencer
    import adc_pkg::*;
#(
    parameter int PERIOD    = 32,
    parameter int CONV_WAIT = 18,
    parameter int AVG_LOG2  = 2
) (
    input  logic                sclk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [ADC_BITS-1:0] voltage,
    output logic                start,
    output logic                channel,
    output logic [ADC_BITS-1:0] sample0,
    output logic [ADC_BITS-1:0] sample1,
    output logic                valid,
    output logic                valid_ch
);

    localparam int PW = $clog2(PERIOD);
    localparam logic [PW-1:0] P_LAST     = PW'(PERIOD - 1);
    localparam logic [PW-1:0] START_LAST = PW'(1);
    localparam logic [PW-1:0] WAIT_LAST  = PW'(CONV_WAIT + 1);

    seq_state_t    state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic          channel_q, channel_d;
    logic          last_ch_q, last_ch_d;
    logic          start_q, start_d;
    logic          go;
    logic          enter_start;
    logic          done0, done1;
    logic          clear_acc;

    assign go = enable && (ch_mask != '0);

    // The period counter doubles as the START/WAIT phase timer: it is 0 on START entry.
    always_comb begin
        state_d     = state_q;
        period_d    = (period_q == P_LAST) ? period_q : period_q + PW'(1);
        channel_d   = channel_q;
        last_ch_d   = last_ch_q;
        enter_start = 1'b0;
        case (state_q)
            IDLE:    if (go) enter_start = 1'b1;
            START:   if (period_q == START_LAST) state_d = WAIT;
            WAIT:    if (period_q == WAIT_LAST) state_d = CAPTURE;
            CAPTURE: state_d = HOLD;
            HOLD: begin
                if (period_q == P_LAST) begin
                    if (go) enter_start = 1'b1;
                    else    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_start) begin
            state_d   = START;
            period_d  = '0;
            channel_d = next_channel(last_ch_q, ch_mask);
            last_ch_d = next_channel(last_ch_q, ch_mask);
        end
        start_d = (state_d == START);
    end

    // last_ch resets to 1 so the first frame after reset picks channel 0.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            period_q  <= '0;
            channel_q <= 1'b0;
            last_ch_q <= 1'b1;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            channel_q <= channel_d;
            last_ch_q <= last_ch_d;
            start_q   <= start_d;
        end
    end

    assign clear_acc = (state_q == IDLE);

    channel_averager #(.AVG_LOG2(AVG_LOG2)) u_avg0 (
        .sclk    (sclk),
        .reset   (reset),
        .add     ((state_q == CAPTURE) && !channel_q),
        .clear   (clear_acc),
        .voltage (voltage),
        .sample  (sample0),
        .done    (done0)
    );

    channel_averager #(.AVG_LOG2(AVG_LOG2)) u_avg1 (
        .sclk    (sclk),
        .reset   (reset),
        .add     ((state_q == CAPTURE) && channel_q),
        .clear   (clear_acc),
        .voltage (voltage),
        .sample  (sample1),
        .done    (done1)
    );

    assign start    = start_q;
    assign channel  = channel_q;
    assign valid    = done0 | done1;
    assign valid_ch = done1;

endmodule

// File: tb/tb_adc_sequencer.sv
// tb/tb_adc_sequencer.sv - scoreboard bench for adc_sequencer with directed ADC values
module tb_adc_sequencer;

    logic       sclk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [1:0] ch_mask = 2'b01;
    logic [9:0] voltage = 10'h200;
    logic       start, channel, valid, valid_ch;
    logic [9:0] sample0, sample1;

    adc_sequencer #(.PERIOD(32), .CONV_WAIT(18), .AVG_LOG2(2)) dut (
        .sclk     (sclk),
        .reset    (reset),
        .enable   (enable),
        .ch_mask  (ch_mask),
        .voltage  (voltage),
        .start    (start),
        .channel  (channel),
        .sample0  (sample0),
        .sample1  (sample1),
        .valid    (valid),
        .valid_ch (valid_ch)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic       ch;
        logic [9:0] s0;
        logic [9:0] s1;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sclk);
    endtask

    // Returns on the first negedge where a new start pulse is visible; w = negedges waited.
    task automatic wait_start(output int w);
        int k;
        k = 0;
        while (start !== 1'b0 && k < 200) begin @(negedge sclk); k++; end
        while (start !== 1'b1 && k < 200) begin @(negedge sclk); k++; end
        w = k;
        if (k >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL start_timeout: no start pulse within 200 cycles, required one");
        end
    endtask

    task automatic frame(input logic [9:0] v);
        int w;
        wait_start(w);
        voltage = v;
    endtask

    task automatic count_start(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge sclk);
            if (start === 1'b1) c++;
        end
    endtask

    // Monitor: every valid strobe pops one expected result.
    always @(negedge sclk) begin
        if (!reset && valid === 1'b1) begin
            exp_t e;
            check("valid_not_back_to_back", prev_valid, 0);
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: valid_ch=%0d sample0=0x%0h sample1=0x%0h, required no valid",
                         valid_ch, sample0, sample1);
            end else begin
                e = q.pop_front();
                check("valid_ch", valid_ch, e.ch);
                check("sample0", sample0, e.s0);
                check("sample1", sample1, e.s1);
            end
        end
        prev_valid <= valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required the bench to complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, c, k;

        // Reset state and constant-input averaging on channel 0
        tick(3);
        check("rst_start", start, 0);
        check("rst_channel", channel, 0);
        check("rst_valid", valid, 0);
        check("rst_valid_ch", valid_ch, 0);
        check("rst_sample0", sample0, 0);
        check("rst_sample1", sample1, 0);
        reset = 1'b0;
        q.push_back('{1'b0, 10'h200, 10'h000});
        for (int i = 0; i < 4; i++) begin
            wait_start(w);
            if (i > 0) check("start_period", w, 32);
            check("t1_channel", channel, 0);
        end
        k = 0;
        while (valid !== 1'b1 && k < 40) begin tick(1); k++; end
        check("valid_latency", k, 21);

        // Truncating average and full-scale without overflow
        q.push_back('{1'b0, 10'd2, 10'h000});
        frame(10'd1);
        tick(1);
        check("start_hi_cycle2", start, 1);
        tick(1);
        check("start_lo_cycle3", start, 0);
        frame(10'd2);
        frame(10'd3);
        frame(10'd5);
        q.push_back('{1'b0, 10'h3FF, 10'h000});
        for (int i = 0; i < 4; i++) frame(10'h3FF);
        tick(25);
        check("t2_drained", q.size(), 0);

        // Round-robin on both channels
        reset = 1'b1;
        tick(2);
        ch_mask = 2'b11;
        reset = 1'b0;
        q.push_back('{1'b0, 10'h100, 10'h000});
        q.push_back('{1'b1, 10'h100, 10'h300});
        for (int i = 0; i < 8; i++) begin
            wait_start(w);
            check("t3_channel", channel, i % 2);
            voltage = (channel === 1'b1) ? 10'h300 : 10'h100;
        end
        tick(25);
        check("t3_drained", q.size(), 0);

        // enable drops mid-frame: partial average discarded on IDLE
        reset = 1'b1;
        tick(2);
        ch_mask = 2'b01;
        reset = 1'b0;
        frame(10'h010);
        frame(10'h010);
        frame(10'h010);
        tick(5);
        enable = 1'b0;
        count_start(60, c);
        check("t4_no_start_when_disabled", c, 0);
        enable = 1'b1;
        q.push_back('{1'b0, 10'h040, 10'h000});
        for (int i = 0; i < 4; i++) frame(10'h040);
        tick(25);
        check("t4_drained", q.size(), 0);

        // Asynchronous reset during WAIT
        ch_mask = 2'b10;
        wait_start(w);
        check("t5_channel_before", channel, 1);
        tick(8);
        #2 reset = 1'b1;
        #1;
        check("t5_start", start, 0);
        check("t5_channel", channel, 0);
        check("t5_valid", valid, 0);
        check("t5_sample0", sample0, 0);
        check("t5_sample1", sample1, 0);
        @(negedge sclk);
        ch_mask = 2'b11;
        reset = 1'b0;
        wait_start(w);
        check("t5_restart_channel", channel, 0);

        // Empty mask holds IDLE; mask change mid-HOLD applies at next START
        reset = 1'b1;
        tick(2);
        ch_mask = 2'b00;
        reset = 1'b0;
        count_start(50, c);
        check("t6_mask00_no_start", c, 0);
        ch_mask = 2'b01;
        wait_start(w);
        check("t6_channel_first", channel, 0);
        tick(25);
        ch_mask = 2'b10;
        tick(1);
        check("t6_channel_held", channel, 0);
        wait_start(w);
        check("t6_period_after_change", w, 6);
        check("t6_channel_next", channel, 1);
        enable = 1'b0;
        tick(40);
        check("final_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
